// File: rtl/external_bus_interface.sv
// external_bus_interface
//   Runs one handshaked access on the external memory bus for each core
//   request. The core presents {addr_high, addr_low}, write_data and rw with
//   req, and is held off through core_stall until the access finishes. Read
//   data comes back on read_data. A wait-state timeout ends an access that
//   the memory never acknowledges.
//
// Parameters
//   MAX_WAIT      cycles in WAIT without mem_ack before timeout (0 = never)
//   TIMEOUT_DATA  byte returned on a read that timed out
//
// Ports
//   clk, nrst                 clock, synchronous active-low reset
//   req, rw                   request strobe, 1 = read / 0 = write
//   addr_low, addr_high       16-bit address from the core
//   write_data                write byte from the core
//   read_data                 registered read byte to the datapath
//   core_stall                combinational freeze for the core
//   done                      one-cycle completion pulse
//   bus_error, err_clear      sticky timeout flag and its clear
//   mem_addr, mem_wdata       registered address / write byte to memory
//   mem_en, mem_we            access active, write cycle
//   mem_ack, mem_rdata        memory completion and read byte
//
// state | meaning
// IDLE  | waiting for req; captures address/data when it arrives
// WAIT  | access presented to memory, counting wait cycles
// DONE  | done pulse cycle; the stale req still held by the core is ignored

module external_bus_interface #(
  parameter int          MAX_WAIT     = 16,
  parameter logic [7:0]  TIMEOUT_DATA = 8'hEA
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req,
  input  logic        rw,
  input  logic [7:0]  addr_low,
  input  logic [7:0]  addr_high,
  input  logic [7:0]  write_data,
  output logic [7:0]  read_data,
  output logic        core_stall,
  output logic        done,
  output logic        bus_error,
  input  logic        err_clear,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_en,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);

  // Counter only has to reach MAX_WAIT-1; it saturates at all-ones.
  localparam int             CW   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0]  LAST = CW'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);
  localparam logic [CW-1:0]  SAT  = '1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [15:0]    mem_addr_n;
  logic [7:0]     mem_wdata_n, read_data_n;
  logic           mem_en_n, mem_we_n, done_n, bus_error_n;
  logic           timeout;

  assign timeout    = (MAX_WAIT != 0) && (cnt == LAST);
  assign core_stall = ((state == IDLE) && req) || (state == WAIT);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      read_data <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      read_data <= read_data_n;
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      done      <= done_n;
      bus_error <= bus_error_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    read_data_n = read_data;
    mem_en_n    = mem_en;
    mem_we_n    = mem_we;
    done_n      = 1'b0;
    // A timeout set takes priority over a clear arriving on the same edge.
    bus_error_n = err_clear ? 1'b0 : bus_error;

    unique case (state)
      IDLE: begin
        if (req) begin
          mem_addr_n = {addr_high, addr_low};
          mem_we_n   = ~rw;
          mem_en_n   = 1'b1;
          if (!rw) mem_wdata_n = write_data;
          cnt_n      = '0;
          state_n    = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          // mem_we still reflects the captured direction of this access.
          if (!mem_we) read_data_n = mem_rdata;
          mem_en_n = 1'b0;
          mem_we_n = 1'b0;
          done_n   = 1'b1;
          state_n  = DONE;
        end else if (timeout) begin
          if (!mem_we) read_data_n = TIMEOUT_DATA;
          bus_error_n = 1'b1;
          mem_en_n    = 1'b0;
          mem_we_n    = 1'b0;
          done_n      = 1'b1;
          state_n     = DONE;
        end else if (cnt != SAT) begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_external_bus_interface.sv
// Testbench for external_bus_interface. A transaction-level model predicts
// the done cycle, returned byte and error flag for each access from its
// direction and acknowledge cycle; directed steps come first, then random
// accesses.

module tb_external_bus_interface;

  localparam int         MAX_WAIT = 4;
  localparam logic [7:0] TDATA    = 8'hEA;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req, rw, err_clear, mem_ack;
  logic [7:0]  addr_low, addr_high, write_data, mem_rdata;
  logic [7:0]  read_data, mem_wdata;
  logic [15:0] mem_addr;
  logic        core_stall, done, bus_error, mem_en, mem_we;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: last returned byte, last written byte, sticky error.
  logic [7:0] rd_m, wd_m;
  logic       err_m;

  external_bus_interface #(.MAX_WAIT(MAX_WAIT), .TIMEOUT_DATA(TDATA)) dut (
    .clk(clk), .nrst(nrst), .req(req), .rw(rw),
    .addr_low(addr_low), .addr_high(addr_high), .write_data(write_data),
    .read_data(read_data), .core_stall(core_stall), .done(done),
    .bus_error(bus_error), .err_clear(err_clear),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One IDLE cycle with req low; optional err_clear and a stray mem_ack.
  task automatic idle(input bit clr, input bit spur);
    @(negedge clk);
    req = 1'b0; err_clear = clr; mem_ack = spur; mem_rdata = 8'($urandom);
    #1;
    chk("idle_mem_en", 16'(mem_en), 16'(0));
    chk("idle_mem_we", 16'(mem_we), 16'(0));
    chk("idle_done", 16'(done), 16'(0));
    chk("idle_stall", 16'(core_stall), 16'(0));
    chk("idle_read_data", 16'(read_data), 16'(rd_m));
    chk("idle_bus_error", 16'(bus_error), 16'(err_m));
    if (clr) err_m = 1'b0;
  endtask

  // Full access: request in cycle 0, mem_ack in cycle ack_at (no ack if
  // ack_at > MAX_WAIT), done expected in min(ack_at, MAX_WAIT)+1. req is
  // held through the DONE cycle as the core would.
  task automatic txn(input bit r, input logic [15:0] a, input logic [7:0] wd,
                     input int ack_at, input logic [7:0] rd, input bit scramble);
    bit tmo, e;
    int last;
    tmo  = (ack_at > MAX_WAIT);
    last = tmo ? MAX_WAIT : ack_at;

    @(negedge clk);
    req = 1'b1; rw = r; addr_high = a[15:8]; addr_low = a[7:0];
    write_data = wd; mem_ack = 1'b0; err_clear = 1'b0; mem_rdata = 8'($urandom);
    #1;
    chk("c0_stall", 16'(core_stall), 16'(1));
    chk("c0_mem_en", 16'(mem_en), 16'(0));
    chk("c0_done", 16'(done), 16'(0));
    chk("c0_bus_error", 16'(bus_error), 16'(err_m));
    if (!r) wd_m = wd;

    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (scramble) begin
        addr_high = 8'($urandom); addr_low = 8'($urandom);
        write_data = 8'($urandom); rw = 1'($urandom);
      end
      e = ($urandom_range(0, 3) == 0);
      err_clear = e;
      mem_ack   = (c == ack_at);
      mem_rdata = (c == ack_at) ? rd : 8'($urandom);
      #1;
      chk("w_mem_en", 16'(mem_en), 16'(1));
      chk("w_mem_we", 16'(mem_we), 16'(!r));
      chk("w_mem_addr", mem_addr, a);
      chk("w_mem_wdata", 16'(mem_wdata), 16'(wd_m));
      chk("w_stall", 16'(core_stall), 16'(1));
      chk("w_done", 16'(done), 16'(0));
      chk("w_read_data", 16'(read_data), 16'(rd_m));
      chk("w_bus_error", 16'(bus_error), 16'(err_m));
      if (c == last && tmo) err_m = 1'b1;
      else if (e)           err_m = 1'b0;
    end

    @(negedge clk);
    rw = r; addr_high = a[15:8]; addr_low = a[7:0]; write_data = wd;
    mem_ack = 1'b0; err_clear = 1'b0; mem_rdata = 8'($urandom);
    if (r) rd_m = tmo ? TDATA : rd;
    #1;
    chk("d_done", 16'(done), 16'(1));
    chk("d_stall", 16'(core_stall), 16'(0));
    chk("d_mem_en", 16'(mem_en), 16'(0));
    chk("d_mem_we", 16'(mem_we), 16'(0));
    chk("d_read_data", 16'(read_data), 16'(rd_m));
    chk("d_bus_error", 16'(bus_error), 16'(err_m));
  endtask

  initial begin
    nrst = 1'b0; req = 1'b0; rw = 1'b0; err_clear = 1'b0; mem_ack = 1'b0;
    addr_low = 8'h00; addr_high = 8'h00; write_data = 8'h00; mem_rdata = 8'h00;
    rd_m = 8'h00; wd_m = 8'h00; err_m = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_en", 16'(mem_en), 16'(0));
    chk("rst_mem_we", 16'(mem_we), 16'(0));
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", 16'(mem_wdata), 16'(0));
    chk("rst_read_data", 16'(read_data), 16'(0));
    chk("rst_done", 16'(done), 16'(0));
    chk("rst_bus_error", 16'(bus_error), 16'(0));
    nrst = 1'b1;
    idle(1'b0, 1'b0);

    // Zero-wait read
    txn(1'b1, 16'h3412, 8'h00, 1, 8'h5A, 1'b0);
    idle(1'b0, 1'b0);

    // Write with 3 wait states, inputs scrambled during WAIT
    txn(1'b0, 16'hFFFE, 8'hC3, 4, 8'h00, 1'b1);
    idle(1'b0, 1'b0);

    // Timeout on a read, sticky error, then clear
    txn(1'b1, 16'h8000, 8'h00, MAX_WAIT + 1, 8'h11, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    // Ack on the last wait cycle wins
    txn(1'b1, 16'h8001, 8'h00, MAX_WAIT, 8'h77, 1'b0);
    idle(1'b0, 1'b0);

    // Back-to-back reads, stray ack in IDLE
    txn(1'b1, 16'h1000, 8'h00, 1, 8'hA1, 1'b0);
    txn(1'b1, 16'h1001, 8'h00, 2, 8'hB2, 1'b0);
    txn(1'b0, 16'h1002, 8'h3C, 1, 8'h00, 1'b0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);

    // Random accesses
    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom), 16'($urandom), 8'($urandom),
          $urandom_range(1, MAX_WAIT + 2), 8'($urandom), 1'($urandom));
      for (int g = 0, n = $urandom_range(0, 2); g < n; g++)
        idle(($urandom_range(0, 2) == 0), 1'($urandom));
    end
    // Leave an error pending so reset is seen to clear it
    txn(1'b1, 16'h2222, 8'h00, MAX_WAIT + 1, 8'h00, 1'b0);

    // Reset in the middle of WAIT
    @(negedge clk);
    req = 1'b1; rw = 1'b1; addr_high = 8'h55; addr_low = 8'hAA;
    mem_ack = 1'b0; err_clear = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_mem_en", 16'(mem_en), 16'(1));
    @(negedge clk);
    nrst = 1'b0; req = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    rd_m = 8'h00; wd_m = 8'h00; err_m = 1'b0;
    #1;
    chk("mrst_mem_en", 16'(mem_en), 16'(0));
    chk("mrst_read_data", 16'(read_data), 16'(0));
    chk("mrst_done", 16'(done), 16'(0));
    chk("mrst_stall", 16'(core_stall), 16'(0));
    chk("mrst_mem_addr", mem_addr, 16'h0000);
    chk("mrst_bus_error", 16'(bus_error), 16'(0));
    idle(1'b0, 1'b0);
    txn(1'b1, 16'h4321, 8'h00, 2, 8'h9D, 1'b0);
    idle(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
